// File: rtl/data_mem_banked.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_banked
//  Brief    : Big-endian byte-lane data memory with load/store requests,
//             alignment checking and a hardware clear sequence.
//  Revision : 1.0 - initial release
// ============================================================================
module data_mem_banked #(
    parameter int          DATA_W    = 32,
    parameter int          ADDR_W    = 9,
    parameter logic [7:0]  INIT_BYTE = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr_req,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [1:0]        i_req_size,
    input  logic              i_req_signed,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_rsp_valid,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_err,
    output logic              o_busy
);

    localparam int c_NBYTES = DATA_W / 8;
    localparam int c_OFF_W  = $clog2(c_NBYTES);
    localparam int c_IDX_W  = ADDR_W - c_OFF_W;
    localparam int c_DEPTH  = (2 ** ADDR_W) / c_NBYTES;

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    state_t              r_state;
    logic [c_IDX_W-1:0]  r_clr_idx;
    logic                r_ready;
    logic                r_busy;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_err;
    logic [DATA_W-1:0]   r_mem [c_DEPTH];

    logic [c_IDX_W-1:0]  w_idx;
    logic [c_OFF_W-1:0]  w_off;
    logic [DATA_W-1:0]   w_rd_word;
    logic                w_accept;
    logic                w_oversize;
    logic                w_misalign;
    logic                w_err;
    logic [DATA_W-1:0]   w_wmask;
    logic [DATA_W-1:0]   w_wlanes;
    logic [DATA_W-1:0]   w_raw;
    logic [DATA_W-1:0]   w_load;

    assign w_idx     = i_req_addr[ADDR_W-1:c_OFF_W];
    assign w_off     = i_req_addr[c_OFF_W-1:0];
    assign w_rd_word = r_mem[w_idx];
    assign w_accept  = i_req_valid & r_ready;

    // Lane j of a word sits at bits [(NBYTES-1-j)*8 +: 8]: offset 0 is the MSB lane.
    always_comb begin
        int   v_off;
        int   v_sb;
        int   v_pos;
        int   v_top;
        logic v_sign;
        v_off      = int'(w_off);
        v_sb       = 1 << i_req_size;
        v_pos      = 0;
        w_oversize = (v_sb > c_NBYTES);
        w_misalign = ((v_off % v_sb) != 0);
        w_err      = w_oversize | w_misalign;
        w_wmask    = '0;
        w_wlanes   = '0;
        w_raw      = '0;
        w_load     = '0;
        for (int j = 0; j < c_NBYTES; j++) begin
            if (!w_oversize && (j >= v_off) && (j < v_off + v_sb)) begin
                v_pos = v_sb - 1 - (j - v_off);
                w_raw[v_pos*8 +: 8]                  = w_rd_word[(c_NBYTES-1-j)*8 +: 8];
                w_wlanes[(c_NBYTES-1-j)*8 +: 8]      = i_req_wdata[v_pos*8 +: 8];
                w_wmask[(c_NBYTES-1-j)*8 +: 8]       = 8'hFF;
            end
        end
        v_top  = w_oversize ? (DATA_W - 1) : (v_sb * 8 - 1);
        v_sign = i_req_signed & w_raw[v_top];
        for (int k = 0; k < DATA_W; k++) begin
            w_load[k] = (k > v_top) ? v_sign : w_raw[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_CLEAR;
            r_clr_idx <= '0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b1;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    if (r_clr_idx == c_IDX_W'(c_DEPTH - 1)) begin
                        r_state   <= S_IDLE;
                        r_clr_idx <= '0;
                        r_ready   <= 1'b1;
                        r_busy    <= 1'b0;
                    end else begin
                        r_clr_idx <= r_clr_idx + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (i_clr_req) begin
                        r_state   <= S_CLEAR;
                        r_clr_idx <= '0;
                        r_ready   <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_CLEAR;
                    r_clr_idx <= '0;
                    r_ready   <= 1'b0;
                    r_busy    <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= w_accept;
            if (w_accept) begin
                r_rsp_err   <= w_err;
                r_rsp_rdata <= (w_err || i_req_we) ? '0 : w_load;
            end
        end
    end

    // A store accepted alongside clr_req lands first; the clear starts a cycle later.
    always_ff @(posedge clk) begin
        if (r_state == S_CLEAR) begin
            r_mem[r_clr_idx] <= {c_NBYTES{INIT_BYTE}};
        end else if (w_accept && i_req_we && !w_err) begin
            r_mem[w_idx] <= (w_rd_word & ~w_wmask) | (w_wlanes & w_wmask);
        end
    end

    assign o_req_ready = r_ready;
    assign o_busy      = r_busy;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_banked.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_banked
//  Brief    : Directed self-checking bench for data_mem_banked (default params).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_banked;

    logic        clk;
    logic        rst;
    logic        r_clr_req;
    logic        r_req_valid;
    logic        w_req_ready;
    logic        r_req_we;
    logic [1:0]  r_req_size;
    logic        r_req_signed;
    logic [8:0]  r_req_addr;
    logic [31:0] r_req_wdata;
    logic        w_rsp_valid;
    logic [31:0] w_rsp_rdata;
    logic        w_rsp_err;
    logic        w_busy;

    int checks;
    int errors;
    int n;

    data_mem_banked dut (
        .clk          (clk),
        .rst          (rst),
        .i_clr_req    (r_clr_req),
        .i_req_valid  (r_req_valid),
        .o_req_ready  (w_req_ready),
        .i_req_we     (r_req_we),
        .i_req_size   (r_req_size),
        .i_req_signed (r_req_signed),
        .i_req_addr   (r_req_addr),
        .i_req_wdata  (r_req_wdata),
        .o_rsp_valid  (w_rsp_valid),
        .o_rsp_rdata  (w_rsp_rdata),
        .o_rsp_err    (w_rsp_err),
        .o_busy       (w_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One request in one cycle; response checked #1 after the accepting edge.
    task automatic req(input string tag, input logic clr, input logic we,
                       input logic [1:0] size, input logic sgn, input logic [8:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata,
                       input logic exp_err);
        chk({tag, "_ready"}, 64'(w_req_ready), 64'd1);
        r_clr_req    = clr;
        r_req_valid  = 1'b1;
        r_req_we     = we;
        r_req_size   = size;
        r_req_signed = sgn;
        r_req_addr   = addr;
        r_req_wdata  = wdata;
        step();
        r_req_valid  = 1'b0;
        r_clr_req    = 1'b0;
        chk({tag, "_valid"}, 64'(w_rsp_valid), 64'd1);
        chk({tag, "_rdata"}, 64'(w_rsp_rdata), 64'(exp_rdata));
        chk({tag, "_err"},   64'(w_rsp_err),   64'(exp_err));
    endtask

    // Counts edges until req_ready rises, bounded so a stuck clear still ends.
    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (!w_req_ready && cnt < 400) begin
            step();
            cnt++;
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        r_clr_req    = 1'b0;
        r_req_valid  = 1'b0;
        r_req_we     = 1'b0;
        r_req_size   = 2'b00;
        r_req_signed = 1'b0;
        r_req_addr   = '0;
        r_req_wdata  = '0;

        step();
        step();
        chk("rst_busy",   64'(w_busy),      64'd1);
        chk("rst_ready",  64'(w_req_ready), 64'd0);
        chk("rst_valid",  64'(w_rsp_valid), 64'd0);
        chk("rst_rdata",  64'(w_rsp_rdata), 64'd0);
        chk("rst_err",    64'(w_rsp_err),   64'd0);

        rst = 1'b0;
        wait_ready(n);
        chk("init_clear_len", 64'(n), 64'd128);
        chk("init_busy_low",  64'(w_busy), 64'd0);
        req("ld_w_000", 1'b0, 1'b0, 2'b10, 1'b0, 9'h000, 32'h0, 32'hFFFF_FFFF, 1'b0);

        req("st_w_010",  1'b0, 1'b1, 2'b10, 1'b0, 9'h010, 32'h1234_5678, 32'h0, 1'b0);
        req("ld_bu_011", 1'b0, 1'b0, 2'b00, 1'b0, 9'h011, 32'h0, 32'h0000_0034, 1'b0);
        req("ld_bs_011", 1'b0, 1'b0, 2'b00, 1'b1, 9'h011, 32'h0, 32'h0000_0034, 1'b0);
        req("ld_hs_012", 1'b0, 1'b0, 2'b01, 1'b1, 9'h012, 32'h0, 32'h0000_5678, 1'b0);
        req("ld_hu_010", 1'b0, 1'b0, 2'b01, 1'b0, 9'h010, 32'h0, 32'h0000_1234, 1'b0);

        req("st_b_021",  1'b0, 1'b1, 2'b00, 1'b0, 9'h021, 32'h0000_0080, 32'h0, 1'b0);
        req("ld_w_020",  1'b0, 1'b0, 2'b10, 1'b0, 9'h020, 32'h0, 32'hFF80_FFFF, 1'b0);
        req("ld_bs_021", 1'b0, 1'b0, 2'b00, 1'b1, 9'h021, 32'h0, 32'hFFFF_FF80, 1'b0);
        req("ld_bu_021", 1'b0, 1'b0, 2'b00, 1'b0, 9'h021, 32'h0, 32'h0000_0080, 1'b0);
        step();
        chk("hold_valid", 64'(w_rsp_valid), 64'd0);
        chk("hold_rdata", 64'(w_rsp_rdata), 64'h0000_0000_0000_0080);
        chk("hold_err",   64'(w_rsp_err),   64'd0);

        req("err_ld_h_001",  1'b0, 1'b0, 2'b01, 1'b1, 9'h001, 32'h0, 32'h0, 1'b1);
        req("err_st_w_002",  1'b0, 1'b1, 2'b10, 1'b0, 9'h002, 32'hDEAD_BEEF, 32'h0, 1'b1);
        req("err_st_d_010",  1'b0, 1'b1, 2'b11, 1'b0, 9'h010, 32'hCAFE_F00D, 32'h0, 1'b1);
        req("err_ld_d_000",  1'b0, 1'b0, 2'b11, 1'b0, 9'h000, 32'h0, 32'h0, 1'b1);
        req("unch_ld_000",   1'b0, 1'b0, 2'b10, 1'b0, 9'h000, 32'h0, 32'hFFFF_FFFF, 1'b0);
        req("unch_ld_010",   1'b0, 1'b0, 2'b10, 1'b0, 9'h010, 32'h0, 32'h1234_5678, 1'b0);

        // Back-to-back store then load of the same word.
        req("st_h_032",  1'b0, 1'b1, 2'b01, 1'b0, 9'h032, 32'h0000_BEEF, 32'h0, 1'b0);
        req("ld_w_030",  1'b0, 1'b0, 2'b10, 1'b0, 9'h030, 32'h0, 32'hFFFF_BEEF, 1'b0);
        req("st_b_034",  1'b0, 1'b1, 2'b00, 1'b0, 9'h034, 32'h1234_567F, 32'h0, 1'b0);
        req("ld_bs_034", 1'b0, 1'b0, 2'b00, 1'b1, 9'h034, 32'h0, 32'h0000_007F, 1'b0);

        req("clr_st_1fc", 1'b1, 1'b1, 2'b10, 1'b0, 9'h1FC, 32'hA5A5_A5A5, 32'h0, 1'b0);
        chk("clr_busy", 64'(w_busy),      64'd1);
        chk("clr_rdy",  64'(w_req_ready), 64'd0);
        r_clr_req = 1'b1;
        step();
        r_clr_req = 1'b0;
        wait_ready(n);
        chk("clr_len", 64'(n + 1), 64'd128);
        req("clr_ld_1fc", 1'b0, 1'b0, 2'b10, 1'b0, 9'h1FC, 32'h0, 32'hFFFF_FFFF, 1'b0);
        req("clr_ld_010", 1'b0, 1'b0, 2'b10, 1'b0, 9'h010, 32'h0, 32'hFFFF_FFFF, 1'b0);

        req("rst_ld_000", 1'b1, 1'b0, 2'b10, 1'b0, 9'h000, 32'h0, 32'hFFFF_FFFF, 1'b0);
        repeat (50) step();
        chk("mid_busy", 64'(w_busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_rdata", 64'(w_rsp_rdata), 64'd0);
        chk("mid_rst_valid", 64'(w_rsp_valid), 64'd0);
        chk("mid_rst_busy",  64'(w_busy),      64'd1);
        chk("mid_rst_ready", 64'(w_req_ready), 64'd0);
        step();
        rst = 1'b0;
        wait_ready(n);
        chk("mid_rst_len", 64'(n), 64'd128);
        req("end_ld_1fc", 1'b0, 1'b0, 2'b10, 1'b0, 9'h1FC, 32'h0, 32'hFFFF_FFFF, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_mem_banked.md
DATA_MEM_BANKED -- requirements
Module: data_mem_banked

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the word width in bits; legal values are 16, 32 and 64.
REQ-002 Parameter ADDR_W, default 9, SHALL set the byte-address width; the memory holds 2^ADDR_W bytes in DEPTH = 2^ADDR_W/(DATA_W/8) words.
REQ-003 Parameter INIT_BYTE, default 8'hFF, SHALL set the value written to every byte by the clear sequence.
REQ-004 Port clk, input, 1 bit, SHALL be the single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1 bit, SHALL be the reset, asynchronous and active-high.
REQ-006 Port clr_req, input, 1 bit, SHALL request a full-memory clear.
REQ-007 Port req_valid, input, 1 bit, SHALL flag a load/store request.
REQ-008 Port req_ready, output, 1 bit, SHALL flag that a request can be accepted this cycle.
REQ-009 Port req_we, input, 1 bit, SHALL select store (1) or load (0).
REQ-010 Port req_size, input, 2 bits, SHALL give access size: 00 byte, 01 half, 10 word32, 11 word64.
REQ-011 Port req_signed, input, 1 bit, SHALL select sign- (1) or zero-extension (0) of loads.
REQ-012 Port req_addr, input, ADDR_W bits, SHALL carry the byte address.
REQ-013 Port req_wdata, input, DATA_W bits, SHALL carry store data, right-justified.
REQ-014 Port rsp_valid, output, 1 bit, SHALL pulse for one cycle per accepted request.
REQ-015 Port rsp_rdata, output, DATA_W bits, SHALL carry load data, right-justified and extended.
REQ-016 Port rsp_err, output, 1 bit, SHALL flag a rejected (misaligned or oversize) request.
REQ-017 Port busy, output, 1 bit, SHALL be high while the clear sequence runs.

Function
REQ-018 Storage SHALL be DATA_W/8 byte lanes, big-endian: byte offset 0 of a word is the most significant lane.
REQ-019 Word index SHALL be req_addr[ADDR_W-1:log2(DATA_W/8)]; byte offset SHALL be the remaining low bits.
REQ-020 A request SHALL be accepted when req_valid and req_ready are both high at a rising edge.
REQ-021 FSM SHALL have states CLEAR and IDLE; req_ready SHALL be 1 only in IDLE; busy SHALL be 1 only in CLEAR.
REQ-022 CLEAR SHALL write {DATA_W/8{INIT_BYTE}} to word index 0..DEPTH-1, one word per cycle, then enter IDLE; duration exactly DEPTH cycles.
REQ-023 clr_req high in IDLE SHALL enter CLEAR at the next edge with index 0; clr_req in CLEAR SHALL be ignored.
REQ-024 A request accepted in the same cycle as clr_req SHALL complete normally before CLEAR overwrites memory.
REQ-025 Latency SHALL be one cycle: rsp_valid=1 at the edge after acceptance, for both loads and stores; otherwise rsp_valid=0.
REQ-026 Error SHALL be raised when the byte offset is not a multiple of the access size, or the size exceeds DATA_W/8 bytes; then memory is unchanged, rsp_err=1, rsp_rdata=0.
REQ-027 Store SHALL write only the addressed lanes, taking the low size*8 bits of req_wdata, most significant byte to lowest offset; other lanes unchanged.
REQ-028 Load SHALL return the addressed bytes right-justified, sign- or zero-extended to DATA_W per req_signed; rsp_err=0.
REQ-029 Store response SHALL return rsp_rdata=0, rsp_err=0.
REQ-030 rsp_rdata and rsp_err SHALL hold their last values while rsp_valid=0.
REQ-031 A load accepted the cycle after a store to the same word SHALL return the stored data.

Reset
REQ-032 On rst assertion rsp_valid, rsp_err, rsp_rdata SHALL be 0 and the FSM SHALL be in CLEAR at index 0 (busy=1, req_ready=0).
REQ-033 After rst deasserts, the clear sequence SHALL run to completion (DEPTH cycles) before req_ready rises.
REQ-034 rst asserted mid-CLEAR SHALL restart the clear from index 0; rst mid-request SHALL drop the pending response.

Verification
REQ-035 Release rst, defaults -> busy=1 for 128 cycles, then req_ready=1; load word at 0x000 returns 32'hFFFFFFFF.
REQ-036 Store word 32'h12345678 at 0x010, load byte at 0x011 unsigned then signed -> 32'h00000034 both; load half 0x012 signed -> 32'h00005678.
REQ-037 Store byte 8'h80 at 0x021, load word 0x020 -> 32'hFF80FFFF; load byte 0x021 signed -> 32'hFFFFFF80.
REQ-038 Load half at 0x001, store word at 0x002, size 11 with DATA_W=32 -> each rsp_err=1, rsp_rdata=0, memory unchanged.
REQ-039 clr_req with store 32'hA5A5A5A5 at 0x1FC in the same cycle -> store response, then busy for 128 cycles; load 0x1FC -> 32'hFFFFFFFF.
REQ-040 Assert rst at clear index 50 -> outputs zero immediately; after release busy lasts a full 128 cycles.
